// File: rtl/merge_sched.sv
`timescale 1ns / 1ps
// merge_sched: scheduler and datapath front end of one two-input merge stage.
// Picks which FWFT FIFO head to consume each cycle, registers it into a one-entry
// output slot with valid/ready handshake, and collapses two run terminators into one.
module merge_sched #(
    parameter int unsigned KEY_W   = 32,
    parameter int unsigned TUPLE_W = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [TUPLE_W-1:0] i_a_data,
    input  logic               i_a_empty,
    output logic               o_a_read,
    input  logic [TUPLE_W-1:0] i_b_data,
    input  logic               i_b_empty,
    output logic               o_b_read,
    output logic [TUPLE_W-1:0] o_data,
    output logic               o_valid,
    input  logic               i_out_ready,
    output logic [CNT_W-1:0]   o_run_count,
    output logic [CNT_W-1:0]   o_stall_count,
    output logic [1:0]         o_state
);

    typedef enum logic [1:0] {
        StMerge  = 2'd0,
        StDrainA = 2'd1,  // B holds its terminator, finish A's run
        StDrainB = 2'd2   // A holds its terminator, finish B's run
    } state_e;

    state_e             state_q, state_d;
    logic [TUPLE_W-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               adv;
    logic               a_zero, b_zero, a_le_b;
    logic               a_rd, b_rd, load, term, stall;
    logic [TUPLE_W-1:0] sel_data;

    assign adv    = ~valid_q | i_out_ready;
    assign a_zero = (i_a_data == '0);
    assign b_zero = (i_b_data == '0);
    // Ties favour A so equal keys keep their input order.
    assign a_le_b = (i_a_data[KEY_W-1:0] <= i_b_data[KEY_W-1:0]);

    // Head selection, pops and FSM next state.
    always_comb begin
        a_rd     = 1'b0;
        b_rd     = 1'b0;
        load     = 1'b0;
        term     = 1'b0;
        stall    = 1'b0;
        sel_data = '0;
        state_d  = state_q;
        case (state_q)
            StMerge: begin
                if (adv) begin
                    if (!i_a_empty && !i_b_empty) begin
                        load = 1'b1;
                        if (a_zero && b_zero) begin
                            a_rd = 1'b1;
                            b_rd = 1'b1;
                            term = 1'b1;
                        end else if (a_zero) begin
                            b_rd     = 1'b1;
                            sel_data = i_b_data;
                            state_d  = StDrainB;
                        end else if (b_zero) begin
                            a_rd     = 1'b1;
                            sel_data = i_a_data;
                            state_d  = StDrainA;
                        end else if (a_le_b) begin
                            a_rd     = 1'b1;
                            sel_data = i_a_data;
                        end else begin
                            b_rd     = 1'b1;
                            sel_data = i_b_data;
                        end
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            StDrainA: begin
                if (adv) begin
                    if (!i_a_empty) begin
                        load = 1'b1;
                        a_rd = 1'b1;
                        if (a_zero) begin
                            // Both runs ended: retire B's held terminator with A's.
                            b_rd    = 1'b1;
                            term    = 1'b1;
                            state_d = StMerge;
                        end else begin
                            sel_data = i_a_data;
                        end
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            StDrainB: begin
                if (adv) begin
                    if (!i_b_empty) begin
                        load = 1'b1;
                        b_rd = 1'b1;
                        if (b_zero) begin
                            a_rd    = 1'b1;
                            term    = 1'b1;
                            state_d = StMerge;
                        end else begin
                            sel_data = i_b_data;
                        end
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            default: state_d = StMerge;
        endcase
        if (i_rst) begin
            a_rd = 1'b0;
            b_rd = 1'b0;
        end
    end

    // Output slot and saturating counters next state.
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        run_cnt_d   = run_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = sel_data;
        end else if (i_out_ready) begin
            valid_d = 1'b0;
        end
        if (term && (run_cnt_q != '1)) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StMerge;
            valid_q     <= 1'b0;
            data_q      <= '0;
            run_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            run_cnt_q   <= run_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_a_read      = a_rd;
    assign o_b_read      = b_rd;
    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_run_count   = run_cnt_q;
    assign o_stall_count = stall_cnt_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_merge_sched.sv
`timescale 1ns / 1ps
// Bench for merge_sched: FIFO models feed runs, expected output comes from a plain
// stable two-way merge of each run pair followed by one terminator.
module tb_merge_sched;

    localparam int unsigned KW = 32;
    localparam int unsigned TW = 64;
    localparam int unsigned CW = 16;

    typedef logic [TW-1:0] tup_t;

    logic          clk = 1'b0;
    logic          i_rst;
    tup_t          i_a_data, i_b_data;
    logic          i_a_empty, i_b_empty;
    logic          o_a_read, o_b_read;
    tup_t          o_data;
    logic          o_valid;
    logic          i_out_ready;
    logic [CW-1:0] o_run_count, o_stall_count;
    logic [1:0]    o_state;

    always #5 clk = ~clk;

    merge_sched #(
        .KEY_W  (KW),
        .TUPLE_W(TW),
        .CNT_W  (CW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_a_data     (i_a_data),
        .i_a_empty    (i_a_empty),
        .o_a_read     (o_a_read),
        .i_b_data     (i_b_data),
        .i_b_empty    (i_b_empty),
        .o_b_read     (o_b_read),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_out_ready  (i_out_ready),
        .o_run_count  (o_run_count),
        .o_stall_count(o_stall_count),
        .o_state      (o_state)
    );

    tup_t        qa[$], qb[$], ta[$], tb_q[$], exp_q[$], got_q[$];
    int unsigned acc_cyc[$];
    logic [1:0]  pop_states[$], pop_kinds[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0, pops_total = 0, nruns = 0, pat_idx = 0;
    int          mode = 0;  // 0: ready high, 1: ready 1,0,0 pattern, 2: random
    bit          a_hold = 0, b_hold = 0, a_shown = 0, b_shown = 0, prev_stall = 0;
    tup_t        prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // A FIFO head, once presented, stays until popped; holds only delay new arrivals.
    task automatic drive();
        i_a_empty = (qa.size() == 0) || (a_hold && !a_shown);
        i_a_data  = i_a_empty ? {$urandom, $urandom} : qa[0];
        a_shown   = !i_a_empty;
        i_b_empty = (qb.size() == 0) || (b_hold && !b_shown);
        i_b_data  = i_b_empty ? {$urandom, $urandom} : qb[0];
        b_shown   = !i_b_empty;
    endtask

    task automatic tick();
        logic ard, brd, acc;
        tup_t d;
        @(negedge clk);
        ard = o_a_read;
        brd = o_b_read;
        acc = o_valid & i_out_ready;
        d   = o_data;
        if (i_rst) begin
            check("rd_in_reset", {62'd0, ard, brd}, 64'd0);
        end else begin
            if (ard) check("a_pop_nonempty", i_a_empty, 0);
            if (brd) check("b_pop_nonempty", i_b_empty, 0);
            check("no_pop_stalled", (ard | brd) & o_valid & ~i_out_ready, 0);
            if (prev_stall) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", o_data, prev_data);
            end
        end
        prev_stall = !i_rst && o_valid && !i_out_ready;
        prev_data  = o_data;
        if (ard | brd) begin
            pop_states.push_back(o_state);
            pop_kinds.push_back({ard, brd});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ard && qa.size() > 0) begin
            void'(qa.pop_front());
            a_shown = 0;
            pops_total++;
        end
        if (brd && qb.size() > 0) begin
            void'(qb.pop_front());
            b_shown = 0;
            pops_total++;
        end
        if (acc) begin
            got_q.push_back(d);
            acc_cyc.push_back(cyc);
        end
        drive();
    endtask

    // Reference: stable merge of one run pair (ties to A), then a single terminator.
    task automatic add_run();
        int i = 0;
        int j = 0;
        foreach (ta[k]) qa.push_back(ta[k]);
        qa.push_back('0);
        foreach (tb_q[k]) qb.push_back(tb_q[k]);
        qb.push_back('0);
        while (i < ta.size() && j < tb_q.size()) begin
            if (ta[i][KW-1:0] <= tb_q[j][KW-1:0]) begin
                exp_q.push_back(ta[i]);
                i++;
            end else begin
                exp_q.push_back(tb_q[j]);
                j++;
            end
        end
        while (i < ta.size()) begin
            exp_q.push_back(ta[i]);
            i++;
        end
        while (j < tb_q.size()) begin
            exp_q.push_back(tb_q[j]);
            j++;
        end
        exp_q.push_back('0);
        nruns++;
    endtask

    task automatic set_ctl();
        case (mode)
            1: begin
                i_out_ready = (pat_idx % 3 == 0);
                pat_idx++;
            end
            2: begin
                i_out_ready = ($urandom_range(0, 9) < 7);
                a_hold      = ($urandom_range(0, 4) == 0);
                b_hold      = ($urandom_range(0, 4) == 0);
            end
            default: i_out_ready = 1'b1;
        endcase
        drive();
    endtask

    task automatic run_until(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned k = 0;
        while (got_q.size() < n && k < budget) begin
            set_ctl();
            tick();
            k++;
        end
        check({tag, "_done"}, got_q.size() >= n, 1);
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_out%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    task automatic do_reset();
        i_rst       = 1'b1;
        a_hold      = 0;
        b_hold      = 0;
        mode        = 0;
        i_out_ready = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        qa.delete();
        qb.delete();
        a_shown = 0;
        b_shown = 0;
        got_q.delete();
        exp_q.delete();
        acc_cyc.delete();
        pop_states.delete();
        pop_kinds.delete();
        pops_total = 0;
        nruns      = 0;
        drive();
    endtask

    task automatic load_basic();
        ta   = {64'd1, 64'd4, 64'd7};
        tb_q = {64'd2, 64'd3, 64'd9};
        add_run();
    endtask

    initial begin
        i_rst       = 1'b1;
        i_out_ready = 1'b1;
        // Reset with non-empty inputs: reads must stay low.
        ta   = {64'd1};
        tb_q = {64'd2};
        add_run();
        drive();
        do_reset();
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_runs", o_run_count, 0);
        check("rst_stalls", o_stall_count, 0);
        check("rst_state", o_state, 0);

        // Starvation on B, then the basic merge completes.
        load_basic();
        b_hold = 1;
        drive();
        repeat (5) tick();
        check("starve_stalls", o_stall_count, 5);
        check("starve_a_left", qa.size(), 4);
        check("starve_b_left", qb.size(), 4);
        check("starve_valid", o_valid, 0);
        b_hold = 0;
        drive();
        run_until(7, 100, "basic");
        compare_out("basic");
        check("basic_runs", o_run_count, 1);
        if (acc_cyc.size() >= 7) check("basic_contig", acc_cyc[6] - acc_cyc[0], 6);

        // Equal keys: A first, then B, then one terminator; 4 pops.
        do_reset();
        ta   = {64'h0000_000A_0000_0005};
        tb_q = {64'h0000_000B_0000_0005};
        add_run();
        drive();
        run_until(3, 50, "tie");
        compare_out("tie");
        check("tie_pops", pops_total, 4);

        // A is an empty run: drain B, A popped only with B's terminator.
        do_reset();
        ta   = {};
        tb_q = {64'd6, 64'd8};
        add_run();
        drive();
        run_until(3, 50, "drain");
        compare_out("drain");
        check("drain_npops", pop_states.size(), 3);
        if (pop_states.size() >= 3) begin
            check("drain_states", {pop_states[0], pop_states[1], pop_states[2]}, 6'b00_10_10);
            check("drain_kinds", {pop_kinds[0], pop_kinds[1], pop_kinds[2]}, 6'b01_01_11);
        end
        check("drain_end_state", o_state, 0);

        // Backpressure with ready pattern 1,0,0 repeating.
        do_reset();
        load_basic();
        mode    = 1;
        pat_idx = 0;
        drive();
        run_until(7, 100, "bp");
        compare_out("bp");
        check("bp_runs", o_run_count, 1);

        // Reset in the middle of a run discards it.
        do_reset();
        load_basic();
        drive();
        run_until(2, 50, "mid");
        i_rst = 1'b1;
        tick();
        check("mid_valid", o_valid, 0);
        check("mid_runs", o_run_count, 0);
        check("mid_stalls", o_stall_count, 0);
        check("mid_state", o_state, 0);
        do_reset();
        ta   = {64'd3};
        tb_q = {64'd1};
        add_run();
        drive();
        run_until(3, 50, "fresh");
        compare_out("fresh");
        check("fresh_runs", o_run_count, 1);

        // Random runs with random backpressure and arrival gaps.
        do_reset();
        for (int r = 0; r < 20; r++) begin
            int unsigned ka, kb;
            ta.delete();
            tb_q.delete();
            ka = $urandom_range(1, 20);
            kb = $urandom_range(1, 20);
            for (int n = $urandom_range(0, 5); n > 0; n--) begin
                ta.push_back({$urandom, ka});
                ka += $urandom_range(0, 3);
            end
            for (int n = $urandom_range(0, 5); n > 0; n--) begin
                tb_q.push_back({$urandom, kb});
                kb += $urandom_range(0, 3);
            end
            add_run();
        end
        mode = 2;
        drive();
        run_until(exp_q.size(), 3000, "rand");
        compare_out("rand");
        check("rand_runs", o_run_count, nruns);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
